alu_result_capture: RTL

ALU_RESULT_CAPTURE -- requirements
Module: alu_result_capture

---
 rtl/alu_result_capture.sv | 128 ++++++++++++
 1 files changed

// File: rtl/alu_result_capture.sv
// ---------------------------------------------------------------------------
// alu_result_capture
//
// Captures ALU results ({opcode, flags, result}) into a first-word
// fall-through FIFO and keeps capture/drop statistics for a downstream
// consumer.
//
// Parameters
//   DEPTH  FIFO entries (power of two, 2..64)
//   CNT_W  width of the saturating capture counter
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   Enable                ALU result strobe (push request)
//   opcode, alu_out       opcode and 32-bit result being captured
//   parity/zero/sign/carry_flag  ALU flags stored with the result
//   clear                 synchronous flush of FIFO, counters and overflow
//   rd_valid/rd_ready     head-entry handshake (pop on valid & ready)
//   rd_data/rd_flags/rd_opcode  head entry, zero while empty
//   level                 current occupancy
//   cap_count             results accepted, saturating at all-ones
//   drop_count            results lost to a full FIFO, saturating at 255
//   overflow              sticky, set on the first drop
// ---------------------------------------------------------------------------
module alu_result_capture #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Enable,
  input  logic [3:0]                 opcode,
  input  logic [31:0]                alu_out,
  input  logic                       parity_flag,
  input  logic                       zero_flag,
  input  logic                       sign_flag,
  input  logic                       carry_flag,
  input  logic                       clear,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [31:0]                rd_data,
  output logic [3:0]                 rd_flags,
  output logic [3:0]                 rd_opcode,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           cap_count,
  output logic [7:0]                 drop_count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 40;

  function automatic logic [CNT_W-1:0] sat_inc_cap(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] sat_inc_drop(input logic [7:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic [CNT_W-1:0] cap_q;
  logic [7:0]    drop_q;
  logic          ovf_q;

  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LW'(DEPTH));
  assign pop      = !empty && rd_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = Enable && (!full || pop);
  assign drop     = Enable && full && !pop;
  assign wr_entry = {opcode, parity_flag, zero_flag, sign_flag, carry_flag, alu_out};

  // ---- capture stage: pointers, occupancy and statistics ----
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      cap_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by natural overflow.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (push_ok) cap_q <= sat_inc_cap(cap_q);
      if (drop) begin
        drop_q <= sat_inc_drop(drop_q);
        ovf_q  <= 1'b1;
      end
    end
  end

  // Storage carries no reset; nothing observable reads it while empty.
  always_ff @(posedge clk) begin
    if (push_ok && !reset && !clear) mem[wr_ptr] <= wr_entry;
  end

  // ---- read side: first-word fall-through, forced to zero when empty ----
  assign head       = mem[rd_ptr];
  assign rd_valid   = !empty;
  assign rd_data    = empty ? 32'd0 : head[31:0];
  assign rd_flags   = empty ? 4'd0  : head[35:32];
  assign rd_opcode  = empty ? 4'd0  : head[39:36];
  assign level      = level_q;
  assign cap_count  = cap_q;
  assign drop_count = drop_q;
  assign overflow   = ovf_q;

endmodule
